relay_mod_sequencer: RTL and testbench



---
 rtl/relay_mod_sequencer.sv | 135 +++++++++++++
 tb/tb_relay_mod_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/relay_mod_sequencer.sv
// Relay-mode modulation sequencer for the ISO14443-A front end: samples the relay
// line at the subcarrier rate, frames bytes, and switches mod_type between listen and modulate.
//
// state    | meaning
// DISABLED | non-relay mode, mod_type mirrors mode_sel
// LISTEN   | relay mode, waiting for the start pattern
// ACTIVE   | relay frame in progress, modulating
module relay_mod_sequencer #(
  parameter int          DIV_LOG2     = 4,
  parameter int          SAMPLE_PHASE = 8,
  parameter int          MAX_BYTES    = 64,
  parameter logic [7:0]  READER_START = 8'hc0,
  parameter logic [7:0]  TAG_START    = 8'hf0
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic [2:0] mode_sel,
  input  logic       relay_in,
  output logic [2:0] mod_type,
  output logic       frame_data,
  output logic       active,
  output logic       sample_strobe,
  output logic       frame_err
);

  localparam int         BW       = $clog2(MAX_BYTES + 1);
  localparam logic [2:0] M_READER = 3'b101;
  localparam logic [2:0] M_TAG    = 3'b110;

  typedef enum logic [1:0] {S_DISABLED, S_LISTEN, S_ACTIVE} state_t;

  state_t              state, state_nx;
  logic [DIV_LOG2-1:0] divider;
  logic                sync1, rbit;
  logic [23:0]         window, window_nx, win_sh;
  logic [2:0]          bit_cnt, bit_cnt_nx, nb;
  logic [BW-1:0]       byte_cnt, byte_cnt_nx;
  logic [2:0]          mode_q;
  logic                frame_data_nx, frame_err_nx;
  logic                relay, is_tag, mode_chg, start_hit, end_hit;
  logic [7:0]          start_pat;

  assign sample_strobe = (divider == DIV_LOG2'(SAMPLE_PHASE));
  assign relay         = (mode_sel == M_READER) || (mode_sel == M_TAG);
  assign is_tag        = (mode_sel == M_TAG);
  assign start_pat     = is_tag ? TAG_START : READER_START;
  assign win_sh        = {window[22:0], rbit};
  assign nb            = bit_cnt + 3'd1;
  assign start_hit     = (win_sh == {16'h0000, start_pat});
  assign end_hit       = is_tag ? (win_sh[15:8] == 8'h00)
                                : ((win_sh[23:8] == 16'h0000) || (win_sh[23:8] == 16'hc000));
  // a relay-mode state implies the previous cycle was also a relay mode
  assign mode_chg      = (state != S_DISABLED) && (mode_sel != mode_q);
  assign active        = (state == S_ACTIVE);

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      divider    <= '0;
      sync1      <= 1'b0;
      rbit       <= 1'b0;
      window     <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      mode_q     <= '0;
      state      <= S_DISABLED;
      frame_data <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      divider    <= divider + DIV_LOG2'(1);
      sync1      <= relay_in;
      rbit       <= sync1;
      window     <= window_nx;
      bit_cnt    <= bit_cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      mode_q     <= mode_sel;
      state      <= state_nx;
      frame_data <= frame_data_nx;
      frame_err  <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    window_nx     = window;
    bit_cnt_nx    = bit_cnt;
    byte_cnt_nx   = byte_cnt;
    frame_data_nx = frame_data;
    frame_err_nx  = 1'b0;
    if (!relay) begin
      state_nx      = S_DISABLED;
      window_nx     = '0;
      bit_cnt_nx    = '0;
      byte_cnt_nx   = '0;
      frame_data_nx = 1'b0;
    end else if (state == S_DISABLED) begin
      state_nx = S_LISTEN;
    end else if (mode_chg) begin
      state_nx      = S_LISTEN;
      window_nx     = '0;
      bit_cnt_nx    = '0;
      byte_cnt_nx   = '0;
      frame_data_nx = 1'b0;
    end else if (sample_strobe) begin
      window_nx     = win_sh;
      frame_data_nx = win_sh[7];
      bit_cnt_nx    = nb;
      if (start_hit) begin
        state_nx    = S_ACTIVE;
        bit_cnt_nx  = '0;
        byte_cnt_nx = '0;
      end else if (state == S_ACTIVE && nb == 3'd0) begin
        if (end_hit) begin
          state_nx = S_LISTEN;
        end else if ((byte_cnt + BW'(1)) == BW'(MAX_BYTES)) begin
          state_nx     = S_LISTEN;
          frame_err_nx = 1'b1;
        end else begin
          byte_cnt_nx = byte_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    mod_type = mode_sel;
    if (relay) begin
      case (state)
        S_LISTEN: mod_type = is_tag ? 3'b011 : 3'b001;
        S_ACTIVE: mod_type = is_tag ? 3'b100 : 3'b010;
        default:  mod_type = mode_sel;
      endcase
    end
  end

endmodule

// File: tb/tb_relay_mod_sequencer.sv
// Bench for relay_mod_sequencer: two instances (default and MAX_BYTES=4) checked every
// cycle against a bit-stream reference model, plus directed boundary checks.
module tb_relay_mod_sequencer;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode_sel = 3'b011;
  logic       relay_in = 1'b0;

  logic [2:0] mt0, mt1;
  logic       fd0, fd1, ac0, ac1, st0, st1, fe0, fe1;

  int n_total = 0;
  int n_bad   = 0;
  int err1_cnt = 0;

  always #5 ck = ~ck;

  relay_mod_sequencer dut0 (
    .ck_1356meg(ck), .rst(rst), .mode_sel(mode_sel), .relay_in(relay_in),
    .mod_type(mt0), .frame_data(fd0), .active(ac0), .sample_strobe(st0), .frame_err(fe0));

  relay_mod_sequencer #(.MAX_BYTES(4)) dut1 (
    .ck_1356meg(ck), .rst(rst), .mode_sel(mode_sel), .relay_in(relay_in),
    .mod_type(mt1), .frame_data(fd1), .active(ac1), .sample_strobe(st1), .frame_err(fe1));

  // Reference model: m_st 0=off, 1=listening, 2=in frame; m_bits = bits since frame start
  int          m_st[2];
  logic [23:0] m_win[2];
  int          m_bits[2];
  logic        m_fd[2], m_err[2];
  int          m_max[2] = '{64, 4};
  logic        m_s1 = 1'b0, m_s2 = 1'b0;
  logic [2:0]  m_prev = 3'b000;
  int          m_cyc = 0;

  always @(posedge ck) begin : model
    logic rb, strobe, rly, tag, endm;
    logic [23:0] w;
    logic [7:0] sp;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_win[k] = '0; m_bits[k] = 0; m_fd[k] = 1'b0; m_err[k] = 1'b0;
      end
      m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 3'b000; m_cyc = 0;
    end else begin
      rb     = m_s2;
      strobe = (m_cyc % 16) == 8;
      rly    = (mode_sel == 3'b101) || (mode_sel == 3'b110);
      tag    = (mode_sel == 3'b110);
      sp     = tag ? 8'hf0 : 8'hc0;
      for (int k = 0; k < 2; k++) begin
        m_err[k] = 1'b0;
        if (!rly) begin
          m_st[k] = 0; m_win[k] = '0; m_bits[k] = 0; m_fd[k] = 1'b0;
        end else if (m_st[k] == 0) begin
          m_st[k] = 1;
        end else if (mode_sel != m_prev) begin
          m_st[k] = 1; m_win[k] = '0; m_bits[k] = 0; m_fd[k] = 1'b0;
        end else if (strobe) begin
          w = {m_win[k][22:0], rb};
          m_win[k] = w;
          m_fd[k]  = w[7];
          if (w == {16'h0000, sp}) begin
            m_st[k] = 2; m_bits[k] = 0;
          end else begin
            m_bits[k]++;
            if (m_st[k] == 2 && (m_bits[k] % 8) == 0) begin
              endm = tag ? (w[15:8] == 8'h00) : (w[23:8] == 16'h0000 || w[23:8] == 16'hc000);
              if (endm) m_st[k] = 1;
              else if (m_bits[k] / 8 == m_max[k]) begin
                m_st[k] = 1; m_err[k] = 1'b1;
              end
            end
          end
        end
      end
      m_s2 = m_s1; m_s1 = relay_in; m_prev = mode_sel; m_cyc++;
    end
  end

  function automatic logic [2:0] exp_mt(int k);
    logic rly, tag;
    rly = (mode_sel == 3'b101) || (mode_sel == 3'b110);
    tag = (mode_sel == 3'b110);
    if (!rly || m_st[k] == 0) return mode_sel;
    if (m_st[k] == 1) return tag ? 3'b011 : 3'b001;
    return tag ? 3'b100 : 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic es;
    es = (m_cyc % 16) == 8;
    chk("mod_type0", 32'(mt0), 32'(exp_mt(0)));
    chk("mod_type1", 32'(mt1), 32'(exp_mt(1)));
    chk("active0", 32'(ac0), 32'(m_st[0] == 2));
    chk("active1", 32'(ac1), 32'(m_st[1] == 2));
    chk("frame_data0", 32'(fd0), 32'(m_fd[0]));
    chk("frame_data1", 32'(fd1), 32'(m_fd[1]));
    chk("frame_err0", 32'(fe0), 32'(m_err[0]));
    chk("frame_err1", 32'(fe1), 32'(m_err[1]));
    chk("strobe0", 32'(st0), 32'(es));
    chk("strobe1", 32'(st1), 32'(es));
    if (fe1 === 1'b1) err1_cnt++;
  endtask

  task automatic tick();
    @(negedge ck);
    check_all();
  endtask

  task automatic send_bit(input logic b);
    relay_in = b;
    repeat (16) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin : stim
    int first;
    int nb;
    logic [2:0] m;

    // reset and passthrough
    repeat (3) tick();
    chk("rst_mod_type", 32'(mt0), 32'h3);
    chk("rst_active", 32'(ac0), 32'h0);
    chk("rst_frame_data", 32'(fd0), 32'h0);
    chk("rst_frame_err", 32'(fe0), 32'h0);
    rst = 1'b0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge ck); #1;
      if (st0 === 1'b1) begin
        first = c;
        break;
      end
    end
    chk("strobe_first", 32'(first), 32'd8);

    // reader frame
    mode_sel = 3'b101;
    repeat (4) tick();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hc0); send_byte(8'h5a);
    chk("reader_active", 32'(ac0), 32'h1);
    chk("reader_mod", 32'(mt0), 32'h2);
    send_byte(8'h3c); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    chk("reader_end_active", 32'(ac0), 32'h0);
    chk("reader_end_mod", 32'(mt0), 32'h1);

    // tag frame with a nibble offset after the start pattern
    mode_sel = 3'b110;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hf0);
    repeat (4) send_bit(1'b0);
    send_byte(8'ha5);
    chk("tag_active", 32'(ac0), 32'h1);
    chk("tag_mod", 32'(mt0), 32'h4);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("tag_end_active", 32'(ac0), 32'h0);
    chk("tag_end_mod", 32'(mt0), 32'h3);

    // randomized frames with random phase jitter
    for (int f = 0; f < 6; f++) begin
      m = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      mode_sel = m;
      relay_in = 1'b0;
      repeat ($urandom_range(0, 15)) tick();
      send_byte(8'h00); send_byte(8'h00);
      send_byte((m == 3'b110) ? 8'hf0 : 8'hc0);
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) send_byte(8'($urandom));
      repeat (4) send_byte(8'h00);
    end

    // timeout: dut1 (4 bytes) times out, dut0 keeps the frame
    mode_sel = 3'b101;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    err1_cnt = 0;
    send_byte(8'hc0);
    repeat (6) send_byte(8'hff);
    chk("timeout_err_pulses", 32'(err1_cnt), 32'd1);
    chk("timeout_active1", 32'(ac1), 32'h0);
    chk("timeout_mod1", 32'(mt1), 32'h1);
    chk("long_frame_active0", 32'(ac0), 32'h1);

    // mode change mid-frame, then drop out of relay
    mode_sel = 3'b110;
    tick();
    chk("modechg_mod", 32'(mt0), 32'h3);
    chk("modechg_active", 32'(ac0), 32'h0);
    repeat (20) tick();
    chk("modechg_fd", 32'(fd0), 32'h0);
    mode_sel = 3'b000;
    #1;
    chk("passthru_same_cycle", 32'(mt0), 32'h0);
    tick();

    // synchronous reset mid-frame
    mode_sel = 3'b101;
    relay_in = 1'b0;
    repeat (3) tick();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hc0); send_byte(8'h00);
    chk("pre_rst_active", 32'(ac0), 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_mid_active", 32'(ac0), 32'h0);
    chk("rst_mid_fd", 32'(fd0), 32'h0);
    chk("rst_mid_err", 32'(fe0), 32'h0);
    chk("rst_mid_mod", 32'(mt0), 32'h5);
    rst = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("post_rst_no_match", 32'(ac0), 32'h0);
    chk("post_rst_mod", 32'(mt0), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
